// File: rtl/forwarding_mp.sv
// Multi-port operand forwarder at the decode/execute boundary: per-port ALU/WB/history/regfile
// selection, registered operands, and a load-use stall FSM with a sticky runaway-stall flag.
module forwarding_mp #(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 5,
    parameter int NPORTS    = 2,
    parameter int HDEPTH    = 2,
    parameter int MAX_STALL = 15
) (
    input  logic                     h_clk,
    input  logic                     h_rst,
    input  logic                     h_i_ce,
    input  logic                     h_i_flush,
    input  logic [NPORTS*DWIDTH-1:0] h_data_reg,
    input  logic [NPORTS*AWIDTH-1:0] h_decoder_addr,
    input  logic                     h_i_valid_alu,
    input  logic                     h_i_we_reg_alu,
    input  logic [AWIDTH-1:0]        h_i_alu_addr_rd,
    input  logic [DWIDTH-1:0]        h_i_alu_data_rd,
    input  logic                     h_i_memoryaccess_ce,
    input  logic                     h_i_we_reg_mem,
    input  logic [AWIDTH-1:0]        h_i_addr_rd_mem,
    input  logic [DWIDTH-1:0]        h_i_data_rd_wb,
    input  logic                     h_i_wb_ce,
    output logic [NPORTS*DWIDTH-1:0] h_data_out,
    output logic [NPORTS*2-1:0]      h_o_fwd_src,
    output logic                     h_alu_force_stall_out,
    output logic                     h_o_stall_timeout
);

    localparam int CW = $clog2(MAX_STALL + 1);

    typedef enum logic {
        ST_IDLE,
        ST_STALL
    } state_t;

    localparam logic [1:0] SRC_REG  = 2'b00;
    localparam logic [1:0] SRC_ALU  = 2'b01;
    localparam logic [1:0] SRC_WB   = 2'b10;
    localparam logic [1:0] SRC_HIST = 2'b11;

    // Retired-write history, entry 0 newest
    logic              hist_valid_q [HDEPTH];
    logic [AWIDTH-1:0] hist_addr_q  [HDEPTH];
    logic [DWIDTH-1:0] hist_data_q  [HDEPTH];
    logic              hist_we;

    logic              hist_hit  [NPORTS];
    logic [DWIDTH-1:0] hist_rdat [NPORTS];

    logic [NPORTS*DWIDTH-1:0] data_d, data_q;
    logic [NPORTS*2-1:0]      src_d, src_q;
    logic                     hazard;

    state_t        state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic          stall_d, stall_q;
    logic          timeout_d, timeout_q;

    assign hist_we = h_i_wb_ce & h_i_we_reg_mem & (h_i_addr_rd_mem != '0);

    // Newest matching entry wins: scan oldest to newest so later hits overwrite.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            hist_hit[p]  = 1'b0;
            hist_rdat[p] = '0;
            for (int i = HDEPTH - 1; i >= 0; i--) begin
                if (hist_valid_q[i] && hist_addr_q[i] == h_decoder_addr[p*AWIDTH +: AWIDTH]) begin
                    hist_hit[p]  = 1'b1;
                    hist_rdat[p] = hist_data_q[i];
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        data_d = h_data_reg;
        src_d  = '0;
        hazard = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            if (h_decoder_addr[p*AWIDTH +: AWIDTH] == '0) begin
                data_d[p*DWIDTH +: DWIDTH] = '0;
            end else if (h_decoder_addr[p*AWIDTH +: AWIDTH] == h_i_alu_addr_rd &&
                         h_i_we_reg_alu && h_i_memoryaccess_ce) begin
                // An invalid ALU result (load in flight) stalls; WB is never a fallback here.
                if (h_i_valid_alu) begin
                    data_d[p*DWIDTH +: DWIDTH] = h_i_alu_data_rd;
                    src_d[p*2 +: 2]            = SRC_ALU;
                end else begin
                    hazard = 1'b1;
                end
            end else if (h_decoder_addr[p*AWIDTH +: AWIDTH] == h_i_addr_rd_mem &&
                         h_i_we_reg_mem && h_i_wb_ce) begin
                data_d[p*DWIDTH +: DWIDTH] = h_i_data_rd_wb;
                src_d[p*2 +: 2]            = SRC_WB;
            end else if (hist_hit[p]) begin
                data_d[p*DWIDTH +: DWIDTH] = hist_rdat[p];
                src_d[p*2 +: 2]            = SRC_HIST;
            end else begin
                src_d[p*2 +: 2]            = SRC_REG;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_d   = stall_q;
        timeout_d = timeout_q;
        if (h_i_flush) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            stall_d   = 1'b0;
            timeout_d = 1'b0;
        end else if (h_i_ce) begin
            stall_d = hazard;
            case (state_q)
                ST_IDLE: begin
                    if (hazard) begin
                        state_d = ST_STALL;
                        cnt_d   = CW'(1);
                    end
                end
                ST_STALL: begin
                    if (hazard) begin
                        if (cnt_q != CW'(MAX_STALL)) cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
            timeout_d = timeout_q | (cnt_d == CW'(MAX_STALL));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge h_clk or negedge h_rst) begin
        if (!h_rst) begin
            data_q    <= '0;
            src_q     <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            stall_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
            if (h_i_flush) begin
                data_q <= '0;
                src_q  <= '0;
            end else if (h_i_ce) begin
                data_q <= data_d;
                src_q  <= src_d;
            end
        end
    end

    // NOTE: only history valid bits are reset; addr/data are qualified by valid and need no reset.
    always_ff @(posedge h_clk or negedge h_rst) begin
        if (!h_rst) begin
            for (int i = 0; i < HDEPTH; i++) hist_valid_q[i] <= 1'b0;
        end else if (hist_we) begin
            hist_valid_q[0] <= 1'b1;
            for (int i = 1; i < HDEPTH; i++) hist_valid_q[i] <= hist_valid_q[i-1];
        end
    end

    always_ff @(posedge h_clk) begin
        if (hist_we) begin
            hist_addr_q[0] <= h_i_addr_rd_mem;
            hist_data_q[0] <= h_i_data_rd_wb;
            for (int i = 1; i < HDEPTH; i++) begin
                hist_addr_q[i] <= hist_addr_q[i-1];
                hist_data_q[i] <= hist_data_q[i-1];
            end
        end
    end

    assign h_data_out            = data_q;
    assign h_o_fwd_src           = src_q;
    assign h_alu_force_stall_out = stall_q;
    assign h_o_stall_timeout     = timeout_q;

endmodule
